pipe_hazard_ctrl: RTL

//  Central hazard/stall controller for the 5-stage pipeline. Drives stall, flush and bubble

---
 rtl/pipe_hazard_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: stall/flush/bubble controls,
// EX-stage forwarding selects and the data-memory wait/timeout sequencer.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1_addr,
   input  logic [4:0]       id_rs2_addr,
   input  logic [4:0]       ex_rs1_addr,
   input  logic [4:0]       ex_rs2_addr,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd_addr,
   input  logic             ex_branch_taken,
   input  logic             ex_jump,
   input  logic             mem_reg_write,
   input  logic [4:0]       mem_rd_addr,
   input  logic             mem_mem_read,
   input  logic             mem_mem_write,
   input  logic             wb_reg_write,
   input  logic [4:0]       wb_rd_addr,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_flush,
   output logic             ex_mem_stall,
   output logic             mem_wb_bubble,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             mem_fault,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   typedef enum logic [1:0] {
      RUN,
      MEM_WAIT,
      FAULT
   } state_t;

   state_t              state;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                mem_acc;
   logic                mem_busy;
   logic                load_use;
   logic                redirect;

   assign mem_acc  = mem_mem_read | mem_mem_write;
   // The request must drop the instant reset asserts, not at the next edge.
   assign dmem_req = rst_n & mem_acc & (state != FAULT);
   assign mem_busy = dmem_req & ~dmem_ready;
   assign redirect = ex_branch_taken | ex_jump;
   assign load_use = ex_mem_read & (ex_rd_addr != 5'd0) &
                     ((ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr));

   always_comb begin
      // NOTE: every output gets a default first so no path through the priority chain infers a latch.
      pc_stall      = 1'b0;
      if_id_stall   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_stall   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_stall  = 1'b0;
      mem_wb_bubble = 1'b0;
      if (state == FAULT || mem_busy) begin
         // A taken branch in EX is held, not flushed, while memory is frozen.
         pc_stall      = 1'b1;
         if_id_stall   = 1'b1;
         id_ex_stall   = 1'b1;
         ex_mem_stall  = 1'b1;
         mem_wb_bubble = 1'b1;
      end else if (redirect) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         pc_stall    = 1'b1;
         if_id_stall = 1'b1;
         id_ex_flush = 1'b1;
      end
   end

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      if (mem_reg_write && mem_rd_addr != 5'd0 && mem_rd_addr == rs)
         return FWD_MEM;
      else if (wb_reg_write && wb_rd_addr != 5'd0 && wb_rd_addr == rs)
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

   assign fwd_a_sel = fwd_sel(ex_rs1_addr);
   assign fwd_b_sel = fwd_sel(ex_rs2_addr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         wait_cnt  <= '0;
         mem_fault <= 1'b0;
         stall_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         case (state)
            RUN: begin
               if (mem_busy) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= WAIT_W'(1);
               end
            end
            MEM_WAIT: begin
               if (dmem_ready) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                  state     <= FAULT;
                  mem_fault <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            FAULT:   state <= FAULT;
            default: state <= RUN;
         endcase
         if (pc_stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
